// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TileLink UL arbiter: round-robin A grant with stall lock, source-MSB tagging, per-master in-flight limit.
// Zero-cycle combinational A and D paths, no buffering; a stalled grant holds until accepted, and a full master is masked until a response frees a slot.
`ifndef TL_ADDR_BITS
  `define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
  `define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
  `define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
  `define TL_SINK_BITS 1
`endif
`ifndef TL_DATA_BYTES
  `define TL_DATA_BYTES 4
`endif

module tl_ul_arbiter_2to1 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2:0]                      m0_a_opcode,
  input  logic [2:0]                      m0_a_param,
  input  logic [`TL_SIZE_BITS-1:0]        m0_a_size,
  input  logic [`TL_SOURCE_BITS-1:0]      m0_a_source,
  input  logic [`TL_ADDR_BITS-1:0]        m0_a_address,
  input  logic [`TL_DATA_BYTES-1:0]       m0_a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]     m0_a_data,
  input  logic                            m0_a_valid,
  output logic                            m0_a_ready,
  output logic [3:0]                      m0_d_opcode,
  output logic [1:0]                      m0_d_param,
  output logic [`TL_SIZE_BITS-1:0]        m0_d_size,
  output logic [`TL_SOURCE_BITS-1:0]      m0_d_source,
  output logic [`TL_SINK_BITS-1:0]        m0_d_sink,
  output logic                            m0_d_denied,
  output logic [`TL_DATA_BYTES*8-1:0]     m0_d_data,
  output logic                            m0_d_valid,
  input  logic                            m0_d_ready,
  input  logic [2:0]                      m1_a_opcode,
  input  logic [2:0]                      m1_a_param,
  input  logic [`TL_SIZE_BITS-1:0]        m1_a_size,
  input  logic [`TL_SOURCE_BITS-1:0]      m1_a_source,
  input  logic [`TL_ADDR_BITS-1:0]        m1_a_address,
  input  logic [`TL_DATA_BYTES-1:0]       m1_a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]     m1_a_data,
  input  logic                            m1_a_valid,
  output logic                            m1_a_ready,
  output logic [3:0]                      m1_d_opcode,
  output logic [1:0]                      m1_d_param,
  output logic [`TL_SIZE_BITS-1:0]        m1_d_size,
  output logic [`TL_SOURCE_BITS-1:0]      m1_d_source,
  output logic [`TL_SINK_BITS-1:0]        m1_d_sink,
  output logic                            m1_d_denied,
  output logic [`TL_DATA_BYTES*8-1:0]     m1_d_data,
  output logic                            m1_d_valid,
  input  logic                            m1_d_ready,
  output logic [2:0]                      s0_a_opcode,
  output logic [2:0]                      s0_a_param,
  output logic [`TL_SIZE_BITS-1:0]        s0_a_size,
  output logic [`TL_SOURCE_BITS-1:0]      s0_a_source,
  output logic [`TL_ADDR_BITS-1:0]        s0_a_address,
  output logic [`TL_DATA_BYTES-1:0]       s0_a_mask,
  output logic [`TL_DATA_BYTES*8-1:0]     s0_a_data,
  output logic                            s0_a_valid,
  input  logic                            s0_a_ready,
  input  logic [3:0]                      s0_d_opcode,
  input  logic [1:0]                      s0_d_param,
  input  logic [`TL_SIZE_BITS-1:0]        s0_d_size,
  input  logic [`TL_SOURCE_BITS-1:0]      s0_d_source,
  input  logic [`TL_SINK_BITS-1:0]        s0_d_sink,
  input  logic                            s0_d_denied,
  input  logic [`TL_DATA_BYTES*8-1:0]     s0_d_data,
  input  logic                            s0_d_valid,
  output logic                            s0_d_ready,
  output logic [CNT_W-1:0]                outstanding0,
  output logic [CNT_W-1:0]                outstanding1,
  output logic                            err
);

  localparam int SRC_W = `TL_SOURCE_BITS;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [2:0]                  opcode;
    logic [2:0]                  param;
    logic [`TL_SIZE_BITS-1:0]    size;
    logic [SRC_W-1:0]            source;
    logic [`TL_ADDR_BITS-1:0]    address;
    logic [`TL_DATA_BYTES-1:0]   mask;
    logic [`TL_DATA_BYTES*8-1:0] data;
  } a_req_t;

  logic [CNT_W-1:0] cnt [2];
  logic             rr_ptr, lock, lock_id;
  logic             elig0, elig1, grant, grant_valid, a_hs, d_dst, d_hs;
  logic [1:0]       inc, dec;
  a_req_t           a_sel;

  assign elig0 = m0_a_valid && (cnt[0] < MAX_C);
  assign elig1 = m1_a_valid && (cnt[1] < MAX_C);

  always_comb begin
    grant = 1'b0;
    if (lock)                grant = lock_id;
    else if (elig0 && elig1) grant = rr_ptr;
    else if (elig1)          grant = 1'b1;
  end

  assign grant_valid = grant ? m1_a_valid : m0_a_valid;
  assign s0_a_valid  = grant ? elig1 : elig0;
  assign a_hs        = s0_a_valid && s0_a_ready;
  assign m0_a_ready  = s0_a_ready && elig0 && !grant;
  assign m1_a_ready  = s0_a_ready && elig1 && grant;

  assign a_sel = grant
    ? a_req_t'{m1_a_opcode, m1_a_param, m1_a_size, m1_a_source, m1_a_address, m1_a_mask, m1_a_data}
    : a_req_t'{m0_a_opcode, m0_a_param, m0_a_size, m0_a_source, m0_a_address, m0_a_mask, m0_a_data};

  assign s0_a_opcode  = a_sel.opcode;
  assign s0_a_param   = a_sel.param;
  assign s0_a_size    = a_sel.size;
  assign s0_a_source  = {grant, a_sel.source[SRC_W-2:0]};
  assign s0_a_address = a_sel.address;
  assign s0_a_mask    = a_sel.mask;
  assign s0_a_data    = a_sel.data;

  // Response owner is the tag bit inserted on the A channel.
  assign d_dst      = s0_d_source[SRC_W-1];
  assign m0_d_valid = s0_d_valid && !d_dst;
  assign m1_d_valid = s0_d_valid && d_dst;
  assign s0_d_ready = d_dst ? m1_d_ready : m0_d_ready;
  assign d_hs       = s0_d_valid && s0_d_ready;

  assign m0_d_opcode = s0_d_opcode;
  assign m1_d_opcode = s0_d_opcode;
  assign m0_d_param  = s0_d_param;
  assign m1_d_param  = s0_d_param;
  assign m0_d_size   = s0_d_size;
  assign m1_d_size   = s0_d_size;
  assign m0_d_source = {1'b0, s0_d_source[SRC_W-2:0]};
  assign m1_d_source = {1'b0, s0_d_source[SRC_W-2:0]};
  assign m0_d_sink   = s0_d_sink;
  assign m1_d_sink   = s0_d_sink;
  assign m0_d_denied = s0_d_denied;
  assign m1_d_denied = s0_d_denied;
  assign m0_d_data   = s0_d_data;
  assign m1_d_data   = s0_d_data;

  assign inc = {a_hs && grant, a_hs && !grant};
  assign dec = {d_hs && d_dst, d_hs && !d_dst};

  assign outstanding0 = cnt[0];
  assign outstanding1 = cnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      rr_ptr  <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      err     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          if (cnt[i] == '0) err <= 1'b1;
          else              cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if (a_hs) begin
        rr_ptr <= ~grant;
        lock   <= 1'b0;
        if (a_sel.source[SRC_W-1]) err <= 1'b1;
      end else if (lock && !grant_valid) begin
        // Withdrawing a stalled request is a protocol violation.
        lock <= 1'b0;
        err  <= 1'b1;
      end else if (s0_a_valid) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Directed bench for tl_ul_arbiter_2to1: inputs driven on falling edges, outputs checked 1ns later.
`ifndef TL_ADDR_BITS
  `define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
  `define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
  `define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
  `define TL_SINK_BITS 1
`endif
`ifndef TL_DATA_BYTES
  `define TL_DATA_BYTES 4
`endif

module tb_tl_ul_arbiter_2to1;
  localparam int SW = `TL_SOURCE_BITS;
  localparam int ZW = `TL_SIZE_BITS;
  localparam int AW = `TL_ADDR_BITS;
  localparam int DB = `TL_DATA_BYTES;
  localparam int KW = `TL_SINK_BITS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [ZW-1:0] m0_a_size, m1_a_size;
  logic [SW-1:0] m0_a_source, m1_a_source;
  logic [AW-1:0] m0_a_address, m1_a_address;
  logic [DB-1:0] m0_a_mask, m1_a_mask;
  logic [DB*8-1:0] m0_a_data, m1_a_data;
  logic m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;
  logic [3:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m1_d_param;
  logic [ZW-1:0] m0_d_size, m1_d_size;
  logic [SW-1:0] m0_d_source, m1_d_source;
  logic [KW-1:0] m0_d_sink, m1_d_sink;
  logic m0_d_denied, m1_d_denied, m0_d_valid, m1_d_valid, m0_d_ready, m1_d_ready;
  logic [DB*8-1:0] m0_d_data, m1_d_data;
  logic [2:0] s0_a_opcode, s0_a_param;
  logic [ZW-1:0] s0_a_size;
  logic [SW-1:0] s0_a_source;
  logic [AW-1:0] s0_a_address;
  logic [DB-1:0] s0_a_mask;
  logic [DB*8-1:0] s0_a_data;
  logic s0_a_valid, s0_a_ready;
  logic [3:0] s0_d_opcode;
  logic [1:0] s0_d_param;
  logic [ZW-1:0] s0_d_size;
  logic [SW-1:0] s0_d_source;
  logic [KW-1:0] s0_d_sink;
  logic s0_d_denied, s0_d_valid, s0_d_ready;
  logic [DB*8-1:0] s0_d_data;
  logic [2:0] outstanding0, outstanding1;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_ul_arbiter_2to1 #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
    .m0_a_data(m0_a_data), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied),
    .m0_d_data(m0_d_data), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
    .m1_a_data(m1_a_data), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied),
    .m1_d_data(m1_d_data), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .s0_a_opcode(s0_a_opcode), .s0_a_param(s0_a_param), .s0_a_size(s0_a_size),
    .s0_a_source(s0_a_source), .s0_a_address(s0_a_address), .s0_a_mask(s0_a_mask),
    .s0_a_data(s0_a_data), .s0_a_valid(s0_a_valid), .s0_a_ready(s0_a_ready),
    .s0_d_opcode(s0_d_opcode), .s0_d_param(s0_d_param), .s0_d_size(s0_d_size),
    .s0_d_source(s0_d_source), .s0_d_sink(s0_d_sink), .s0_d_denied(s0_d_denied),
    .s0_d_data(s0_d_data), .s0_d_valid(s0_d_valid), .s0_d_ready(s0_d_ready),
    .outstanding0(outstanding0), .outstanding1(outstanding1), .err(err)
  );

  task automatic idle();
    m0_a_opcode = 3'd4; m0_a_param = '0; m0_a_size = 3'd2; m0_a_source = '0;
    m0_a_address = '0; m0_a_mask = '1; m0_a_data = '0; m0_a_valid = 1'b0;
    m1_a_opcode = 3'd4; m1_a_param = '0; m1_a_size = 3'd2; m1_a_source = '0;
    m1_a_address = '0; m1_a_mask = '1; m1_a_data = '0; m1_a_valid = 1'b0;
    m0_d_ready = 1'b0; m1_d_ready = 1'b0; s0_a_ready = 1'b0;
    s0_d_opcode = '0; s0_d_param = '0; s0_d_size = '0; s0_d_source = '0;
    s0_d_sink = '0; s0_d_denied = 1'b0; s0_d_data = '0; s0_d_valid = 1'b0;
  endtask

  // Advance to the next falling edge, passing one rising edge.
  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (outstanding0 !== 3'd0 || outstanding1 !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", outstanding0, outstanding1); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if ({s0_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s0_d_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 000000", {s0_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s0_d_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    m0_a_valid = 1'b1; m0_a_source = 8'h01; m0_a_address = 32'h0000_0100; s0_a_ready = 1'b1;
    #1;
    checks++; if (s0_a_valid !== 1'b1 || m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin
      errors++; $display("FAIL single_a_hs: got v=%b r0=%b r1=%b expected 1 1 0", s0_a_valid, m0_a_ready, m1_a_ready); end
    checks++; if (s0_a_source !== 8'h01 || s0_a_address !== 32'h100 || s0_a_opcode !== 3'd4) begin
      errors++; $display("FAIL single_a_fields: got src=%h addr=%h op=%0d expected 01 100 4", s0_a_source, s0_a_address, s0_a_opcode); end
    next();
    idle();
    #1;
    checks++; if (outstanding0 !== 3'd1) begin errors++; $display("FAIL single_cnt_inc: got %0d expected 1", outstanding0); end
    s0_d_valid = 1'b1; s0_d_source = 8'h01; s0_d_opcode = 4'd1; s0_d_data = 32'hCAFE_F00D; m0_d_ready = 1'b1;
    #1;
    checks++; if (m0_d_valid !== 1'b1 || m1_d_valid !== 1'b0 || s0_d_ready !== 1'b1) begin
      errors++; $display("FAIL single_d_route: got v0=%b v1=%b rdy=%b expected 1 0 1", m0_d_valid, m1_d_valid, s0_d_ready); end
    checks++; if (m0_d_source !== 8'h01 || m0_d_data !== 32'hCAFE_F00D || m1_d_opcode !== 4'd1) begin
      errors++; $display("FAIL single_d_fields: got src=%h data=%h op=%0d expected 01 cafef00d 1", m0_d_source, m0_d_data, m1_d_opcode); end
    next();
    idle();
    #1;
    checks++; if (outstanding0 !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL single_cnt_dec: got %0d err=%b expected 0 0", outstanding0, err); end
  endtask

  task automatic test_contention();
    do_reset();
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; m0_a_source = 8'h05; m1_a_source = 8'h05; s0_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (m0_a_ready !== (k % 2 == 0) || m1_a_ready !== (k % 2 == 1)) begin
        errors++; $display("FAIL contention_grant%0d: got r0=%b r1=%b expected %b %b", k, m0_a_ready, m1_a_ready, k % 2 == 0, k % 2 == 1); end
      checks++; if (s0_a_source !== ((k % 2 == 1) ? 8'h85 : 8'h05)) begin
        errors++; $display("FAIL contention_src%0d: got %h expected %h", k, s0_a_source, (k % 2 == 1) ? 8'h85 : 8'h05); end
      next();
    end
    idle();
    #1;
    checks++; if (outstanding0 !== 3'd2 || outstanding1 !== 3'd2) begin
      errors++; $display("FAIL contention_cnt: got %0d/%0d expected 2/2", outstanding0, outstanding1); end
  endtask

  task automatic test_lock();
    do_reset();
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; m1_a_source = 8'h07; s0_a_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s0_a_ready = (k == 3);
      #1;
      checks++; if (s0_a_valid !== 1'b1 || s0_a_source[7] !== 1'b0 || m1_a_ready !== 1'b0 || m0_a_ready !== (k == 3)) begin
        errors++; $display("FAIL lock_cycle%0d: got v=%b msb=%b r0=%b r1=%b expected 1 0 %b 0", k, s0_a_valid, s0_a_source[7], m0_a_ready, m1_a_ready, k == 3); end
      next();
    end
    #1;
    checks++; if (m1_a_ready !== 1'b1 || m0_a_ready !== 1'b0 || s0_a_source !== 8'h87) begin
      errors++; $display("FAIL lock_release: got r1=%b r0=%b src=%h expected 1 0 87", m1_a_ready, m0_a_ready, s0_a_source); end
    next();
    idle();
  endtask

  task automatic test_limit();
    do_reset();
    m1_a_valid = 1'b1; m1_a_source = 8'h02; s0_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (m1_a_ready !== 1'b1) begin errors++; $display("FAIL limit_accept%0d: got %b expected 1", k, m1_a_ready); end
      next();
    end
    m0_a_valid = 1'b1;
    #1;
    checks++; if (outstanding1 !== 3'd4 || m1_a_ready !== 1'b0 || m0_a_ready !== 1'b1) begin
      errors++; $display("FAIL limit_full: got cnt=%0d r1=%b r0=%b expected 4 0 1", outstanding1, m1_a_ready, m0_a_ready); end
    next();
    m0_a_valid = 1'b0;
    s0_d_valid = 1'b1; s0_d_source = 8'h82; m1_d_ready = 1'b1;
    #1;
    checks++; if (m1_d_valid !== 1'b1 || m0_d_valid !== 1'b0 || m1_d_source !== 8'h02 || m1_a_ready !== 1'b0 || s0_a_valid !== 1'b0) begin
      errors++; $display("FAIL limit_free_same_cycle: got dv1=%b dv0=%b dsrc=%h r1=%b av=%b expected 1 0 02 0 0", m1_d_valid, m0_d_valid, m1_d_source, m1_a_ready, s0_a_valid); end
    next();
    s0_d_valid = 1'b0; m1_d_ready = 1'b0;
    #1;
    checks++; if (outstanding1 !== 3'd3 || m1_a_ready !== 1'b1) begin
      errors++; $display("FAIL limit_free_next: got cnt=%0d r1=%b expected 3 1", outstanding1, m1_a_ready); end
    next();
    idle();
    #1;
    checks++; if (outstanding1 !== 3'd4 || outstanding0 !== 3'd1) begin
      errors++; $display("FAIL limit_final_cnt: got %0d/%0d expected 1/4", outstanding0, outstanding1); end
  endtask

  task automatic test_errors();
    do_reset();
    s0_d_valid = 1'b1; s0_d_source = 8'h02; m0_d_ready = 1'b1;
    #1;
    checks++; if (s0_d_ready !== 1'b1 || m0_d_valid !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL err_spurious_pre: got rdy=%b dv0=%b err=%b expected 1 1 0", s0_d_ready, m0_d_valid, err); end
    next();
    idle();
    #1;
    checks++; if (err !== 1'b1 || outstanding0 !== 3'd0) begin
      errors++; $display("FAIL err_spurious: got err=%b cnt=%0d expected 1 0", err, outstanding0); end
    do_reset();
    m0_a_valid = 1'b1; m0_a_source = 8'h83; s0_a_ready = 1'b1;
    #1;
    checks++; if (s0_a_source !== 8'h03 || m0_a_ready !== 1'b1) begin
      errors++; $display("FAIL err_msb_src: got src=%h r0=%b expected 03 1", s0_a_source, m0_a_ready); end
    next();
    idle();
    #1;
    checks++; if (err !== 1'b1 || outstanding0 !== 3'd1) begin
      errors++; $display("FAIL err_msb_flag: got err=%b cnt=%0d expected 1 1", err, outstanding0); end
    do_reset();
    m1_a_valid = 1'b1;
    next();
    m1_a_valid = 1'b0;
    next();
    #1;
    checks++; if (err !== 1'b1 || outstanding1 !== 3'd0) begin
      errors++; $display("FAIL err_lock_drop: got err=%b cnt=%0d expected 1 0", err, outstanding1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_a_valid = 1'b1; m0_a_source = 8'h81; s0_a_ready = 1'b1;
    next();
    next();
    idle();
    #1;
    checks++; if (outstanding0 !== 3'd2 || err !== 1'b1) begin
      errors++; $display("FAIL arst_setup: got cnt=%0d err=%b expected 2 1", outstanding0, err); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (outstanding0 !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got cnt=%0d err=%b expected 0 0", outstanding0, err); end
    #1 rst_n = 1'b1;
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; s0_a_ready = 1'b1;
    #1;
    checks++; if (m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin
      errors++; $display("FAIL arst_rr_ptr: got r0=%b r1=%b expected 1 0", m0_a_ready, m1_a_ready); end
    next();
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_limit();
    test_errors();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
